// File: rtl/fifo_param_fwft.sv
// Parameterised synchronous FIFO with status flags, sticky error flags and
// a selectable registered or first-word-fall-through read port.
module fifo_param_fwft #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH_P  = 3,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned FWFT     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               put,
    input  logic               get,
    input  logic               flush,
    output logic [WIDTH-1:0]   data_out,
    output logic [DEPTH_P:0]   fillcount,
    output logic               empty,
    output logic               full,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned DEPTH = 2 ** DEPTH_P;
    localparam int unsigned CW    = DEPTH_P + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_P-1:0] wr_ptr;
    logic [DEPTH_P-1:0] rd_ptr;
    logic               get_acc;
    logic               put_acc;

    // Status flags decode from the registered occupancy count.
    assign empty        = (fillcount == CW'(0));
    assign full         = (fillcount == CW'(DEPTH));
    assign almost_full  = (fillcount >= CW'(AF_LEVEL));
    assign almost_empty = (fillcount <= CW'(AE_LEVEL));

    // A read frees a slot in the same cycle, so a put into a full FIFO is
    // accepted when it is paired with a valid get.
    assign get_acc = get && !empty;
    assign put_acc = put && (!full || get_acc);

    // Storage array; contents survive reset and flush, only pointers move.
    always_ff @(posedge clk) begin
        if (!flush && put_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy; flush overrides any concurrent put or get.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fillcount <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fillcount <= '0;
        end else begin
            if (put_acc) begin
                wr_ptr <= wr_ptr + DEPTH_P'(1);
            end
            if (get_acc) begin
                rd_ptr <= rd_ptr + DEPTH_P'(1);
            end
            if (put_acc && !get_acc) begin
                fillcount <= fillcount + CW'(1);
            end else if (get_acc && !put_acc) begin
                fillcount <= fillcount - CW'(1);
            end
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (put && !put_acc) begin
                overflow <= 1'b1;
            end
            if (get && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word presented directly; forced to zero while empty so the
            // port reads zero during reset.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            // Registered read port, updated only by an accepted get.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_out <= '0;
                end else if (!flush && get_acc) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param_fwft.sv
// Self-checking bench: registered and FWFT instances driven in lock step and
// compared against a queue-based reference model.
module tb_fifo_param_fwft;

    localparam int unsigned W     = 32;
    localparam int unsigned DP    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  data_in;
    logic          put, get, flush;

    logic [W-1:0]  dout0, dout1;
    logic [DP:0]   fill0, fill1;
    logic          empty0, full0, af0, ae0, ovf0, unf0;
    logic          empty1, full1, af1, ae1, ovf1, unf1;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0]  q[$];
    logic          m_ovf, m_unf;
    logic [W-1:0]  m_dout;

    always #5 clk = ~clk;

    fifo_param_fwft #(.WIDTH(W), .DEPTH_P(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .put(put), .get(get), .flush(flush),
        .data_out(dout0), .fillcount(fill0), .empty(empty0), .full(full0),
        .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0)
    );

    fifo_param_fwft #(.WIDTH(W), .DEPTH_P(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .put(put), .get(get), .flush(flush),
        .data_out(dout1), .fillcount(fill1), .empty(empty1), .full(full1),
        .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic model_clear();
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
    endtask

    // Drive one cycle, advance the model at the edge, return 1 time unit later.
    task automatic step(input logic p, input logic g, input logic f, input logic [W-1:0] d);
        bit ga, pa;
        put = p; get = g; flush = f; data_in = d;
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            ga = g && (q.size() > 0);
            pa = p && ((q.size() < DEPTH) || ga);
            if (g && q.size() == 0) m_unf = 1'b1;
            if (p && !pa)           m_ovf = 1'b1;
            if (ga) m_dout = q.pop_front();
            if (pa) q.push_back(d);
        end
        #1;
        put = 1'b0; get = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 0, '0);
        vectors++; if (fill0 !== 4'd0 || fill1 !== 4'd0) begin miscompares++; $display("FAIL reset_fill got %0d/%0d want 0", fill0, fill1); end
        vectors++; if ({empty0, ae0, full0, af0} !== 4'b1100) begin miscompares++; $display("FAIL reset_flags got e/ae/f/af=%b want 1100", {empty0, ae0, full0, af0}); end
        vectors++; if ({ovf0, unf0, ovf1, unf1} !== 4'b0000) begin miscompares++; $display("FAIL reset_sticky got %b want 0000", {ovf0, unf0, ovf1, unf1}); end
        vectors++; if (dout0 !== '0 || dout1 !== '0) begin miscompares++; $display("FAIL reset_dout got %h/%h want 0", dout0, dout1); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, W'(i * 'h11));
            vectors++; if (fill0 !== 4'(i + 1)) begin miscompares++; $display("FAIL fill_count got %0d want %0d", fill0, i + 1); end
            vectors++;
            if ({ae0, af0, full0} !== {(i + 1) <= 1, (i + 1) >= 6, (i + 1) == 8}) begin
                miscompares++; $display("FAIL fill_flags at %0d got ae/af/f=%b", i + 1, {ae0, af0, full0});
            end
            vectors++; if (dout1 !== W'(0)) begin miscompares++; $display("FAIL fill_fwft_head got %h want 0", dout1); end
        end
        step(1, 0, 0, W'('h88));
        vectors++; if (ovf0 !== 1'b1 || fill0 !== 4'd8) begin miscompares++; $display("FAIL fill_overflow got ovf=%b fill=%0d want 1/8", ovf0, fill0); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, '0);
            vectors++; if (dout0 !== W'(i * 'h11)) begin miscompares++; $display("FAIL drain_data got %h want %h", dout0, W'(i * 'h11)); end
        end
        step(0, 1, 0, '0);
        vectors++; if (unf0 !== 1'b1 || dout0 !== W'('h77) || fill0 !== 4'd0) begin
            miscompares++; $display("FAIL drain_underflow got unf=%b dout=%h fill=%0d want 1/77/0", unf0, dout0, fill0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, W'(i * 'h11));
        step(1, 1, 0, W'('h99));
        vectors++; if (fill0 !== 4'd8 || ovf0 !== 1'b0 || dout0 !== W'(0)) begin
            miscompares++; $display("FAIL both_full got fill=%0d ovf=%b dout=%h want 8/0/0", fill0, ovf0, dout0);
        end
        for (int i = 1; i < 9; i++) begin
            step(0, 1, 0, '0);
            vectors++;
            if (dout0 !== ((i == 8) ? W'('h99) : W'(i * 'h11))) begin
                miscompares++; $display("FAIL both_order step %0d got %h", i, dout0);
            end
        end
        step(1, 1, 0, W'('hAA));
        vectors++; if (fill0 !== 4'd1 || unf0 !== 1'b1 || dout1 !== W'('hAA)) begin
            miscompares++; $display("FAIL both_empty got fill=%0d unf=%b head=%h want 1/1/aa", fill0, unf0, dout1);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, W'($urandom));
        step(1, 0, 1, W'('h55));
        vectors++; if (fill0 !== 4'd0 || empty0 !== 1'b1) begin miscompares++; $display("FAIL flush_clear got fill=%0d empty=%b want 0/1", fill0, empty0); end
        step(1, 0, 0, W'('hAB));
        vectors++; if (dout1 !== W'('hAB)) begin miscompares++; $display("FAIL flush_fwft got %h want ab", dout1); end
        step(0, 1, 0, '0);
        vectors++; if (dout0 !== W'('hAB)) begin miscompares++; $display("FAIL flush_read got %h want ab", dout0); end
    endtask

    task automatic test_fwft();
        do_reset();
        step(1, 0, 0, W'('h17));
        vectors++; if (dout1 !== W'('h17) || empty1 !== 1'b0) begin miscompares++; $display("FAIL fwft_head got %h empty=%b want 17/0", dout1, empty1); end
        step(1, 0, 0, W'('h18));
        step(0, 1, 0, '0);
        vectors++; if (dout1 !== W'('h18)) begin miscompares++; $display("FAIL fwft_next got %h want 18", dout1); end
        step(1, 0, 0, W'('h19));
        #2 reset = 1'b1;
        #1;
        vectors++; if (fill0 !== 4'd0 || fill1 !== 4'd0 || empty1 !== 1'b1 || dout0 !== '0) begin
            miscompares++; $display("FAIL async_reset got fill=%0d/%0d empty=%b dout=%h", fill0, fill1, empty1, dout0);
        end
        model_clear();
        #1 reset = 1'b0;
        step(1, 0, 0, W'('h21));
        vectors++; if (fill0 !== 4'd1 || dout1 !== W'('h21)) begin miscompares++; $display("FAIL post_reset got fill=%0d head=%h", fill0, dout1); end
    endtask

    task automatic test_random();
        int pp, gp;
        bit p, g, f;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            case ((n / 75) % 4)
                0: begin pp = 80; gp = 20; end
                1: begin pp = 20; gp = 80; end
                2: begin pp = 50; gp = 50; end
                default: begin pp = 95; gp = 60; end
            endcase
            f = ($urandom_range(0, 99) < 2);
            p = !f && ($urandom_range(0, 99) < pp);
            g = !f && ($urandom_range(0, 99) < gp);
            step(p, g, f, W'($urandom));
            vectors++;
            if (fill0 !== 4'(q.size()) || fill1 !== 4'(q.size())) begin
                miscompares++; $display("FAIL rnd_fill cyc %0d got %0d/%0d want %0d", n, fill0, fill1, q.size());
            end
            vectors++;
            if ({empty0, full0, af0, ae0} !== {q.size() == 0, q.size() == DEPTH, q.size() >= AF, q.size() <= AE}) begin
                miscompares++; $display("FAIL rnd_flags cyc %0d got e/f/af/ae=%b size=%0d", n, {empty0, full0, af0, ae0}, q.size());
            end
            vectors++;
            if ({ovf0, unf0} !== {m_ovf, m_unf}) begin
                miscompares++; $display("FAIL rnd_sticky cyc %0d got %b want %b", n, {ovf0, unf0}, {m_ovf, m_unf});
            end
            vectors++;
            if (dout0 !== m_dout) begin miscompares++; $display("FAIL rnd_dout cyc %0d got %h want %h", n, dout0, m_dout); end
            if (q.size() > 0) begin
                vectors++;
                if (dout1 !== q[0]) begin miscompares++; $display("FAIL rnd_head cyc %0d got %h want %h", n, dout1, q[0]); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; put = 1'b0; get = 1'b0; flush = 1'b0; data_in = '0;
        model_clear();
        #12 reset = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_fwft();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_param_fwft.md
FIFO_PARAM_FWFT -- requirements
Module: fifo_param_fwft

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter DEPTH_P, default 3: log2 of depth; DEPTH = 2**DEPTH_P (default 8).
REQ-003 Parameter AF_LEVEL, default 6: almost_full threshold, in words.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty threshold, in words.
REQ-005 Parameter FWFT, default 0: read mode; 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 data_in  input  WIDTH  write data, sampled when put is accepted.
REQ-009 put  input  1  write request.
REQ-010 get  input  1  read request.
REQ-011 flush  input  1  synchronous clear of contents.
REQ-012 data_out  output  WIDTH  read data.
REQ-013 fillcount  output  DEPTH_P+1  number of stored words, 0..DEPTH.
REQ-014 empty  output  1  high when fillcount == 0.
REQ-015 full  output  1  high when fillcount == DEPTH.
REQ-016 almost_full  output  1  high when fillcount >= AF_LEVEL.
REQ-017 almost_empty  output  1  high when fillcount <= AE_LEVEL.
REQ-018 overflow  output  1  sticky: a put was dropped.
REQ-019 underflow  output  1  sticky: a get was dropped.

Function
REQ-020 Storage: DEPTH x WIDTH array with DEPTH_P-bit write and read pointers; each pointer wraps from DEPTH-1 to 0.
REQ-021 Get accepted = get && !empty; put accepted = put && (!full || get accepted).
REQ-022 Full with put and get together: both are accepted, fillcount is unchanged, and overflow is not set.
REQ-023 Empty with put and get together: put is accepted, get is dropped, fillcount becomes 1, and underflow is set.
REQ-024 Accepted put: mem[wr_ptr] <= data_in and wr_ptr increments; accepted get: rd_ptr increments.
REQ-025 fillcount is registered: +1 on put only, -1 on get only, unchanged on both or neither.
REQ-026 empty, full, almost_full and almost_empty decode combinationally from registered fillcount, so they change in the cycle after the causing edge.
REQ-027 FWFT=0: on an accepted get, data_out <= mem[rd_ptr] at that edge (1-cycle latency); otherwise data_out holds.
REQ-028 FWFT=1: data_out = mem[rd_ptr] continuously; the head word is valid in the cycle after its put while empty was high; data_out is unchecked while empty=1.
REQ-029 overflow is set at the edge where put=1 and put is not accepted; data_in is discarded.
REQ-030 underflow is set at the edge where get=1 and empty=1; pointers and data_out are unchanged.
REQ-031 overflow and underflow stay high until reset; flush does not clear them.
REQ-032 flush=1 has priority over put and get: at the edge, wr_ptr, rd_ptr and fillcount go to 0; the array is not cleared; data_out holds when FWFT=0.
REQ-033 Parameter legality: 1 <= AE_LEVEL < AF_LEVEL <= DEPTH and DEPTH_P >= 1; illegal values are unsupported.

Reset
REQ-034 While reset=1, independent of clk: pointers=0, fillcount=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-035 Reset asserted mid-operation discards all contents; after release the first put behaves as into an empty FIFO.

Verification
REQ-036 Reset, then idle -> fillcount=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-037 Defaults; 8 puts of 0x00..0x77 -> almost_empty low once fillcount=2, almost_full high at fillcount=6, full=1 at fillcount=8; 9th put of 0x88 -> overflow=1, fillcount stays 8.
REQ-038 FWFT=0, from full: 8 gets -> data_out 0x00..0x77, each one cycle after its get edge; 9th get -> underflow=1, data_out holds 0x77, fillcount=0.
REQ-039 Full with put=1, get=1, data_in=0x99 for one cycle -> fillcount stays 8, overflow stays 0, 0x99 is read after 0x11..0x77; empty with put=1, get=1 -> fillcount=1, underflow=1.
REQ-040 5 words stored, flush with put=1 -> fillcount=0, empty=1; then put 0xAB and get -> data_out=0xAB.
REQ-041 FWFT=1: put 0x17 into empty -> next cycle data_out=0x17 and empty=0; put 0x18, get -> data_out=0x18; async reset pulse between clock edges -> fillcount=0 immediately.
